// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM states, reset PC and
// the address-window check used by both the fetch and preload paths.
package imem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;
   localparam logic [31:0] RV_NOP       = 32'h0000_0013;

   // Unsigned offset compare: addresses below base wrap to large values and fall outside.
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] span);
      return (addr - base) < span;
   endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch port between the core (master) and the instruction-memory responder (slave).
interface imem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/imem_array.sv
// Word-wide instruction store: one synchronous write port and one registered read port.
// A read and write to the same word on one edge returns the pre-write contents.
module imem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Storage is deliberately not reset so preloaded code survives a core reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/imem_responder.sv
// Serving end of the core fetch port: fixed wait-state latency, one request in flight,
// misaligned/out-of-window fetches answered with an error instead of array data.
module imem_responder
   import imem_pkg::*;
#(
   parameter logic [31:0] BASE        = NPC_RESET_PC,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2
) (
   input  logic              clk,
   input  logic              reset,
   imem_responder_if.slave   bus,
   input  logic              load_en,
   input  logic [31:0]       load_addr,
   input  logic [31:0]       load_data
);

   localparam int          AW       = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          err_q;
   logic          accept;
   logic          req_err;
   logic          load_ok;
   logic [AW-1:0] rd_idx, wr_idx;
   logic [31:0]   rd_word;

   assign req_err = (bus.req_addr[1:0] != 2'b00) || !in_window(bus.req_addr, BASE, SPAN);
   assign rd_idx  = AW'((bus.req_addr - BASE) >> 2);

   // Low preload address bits cannot change the window result: BASE and SPAN are word multiples.
   assign load_ok = in_window(load_addr, BASE, SPAN);
   assign wr_idx  = AW'((load_addr - BASE) >> 2);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      accept        = 1'b0;
      case (state_q)
         IDLE: bus.req_ready = reset;
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = RESP;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            bus.req_ready = reset & bus.rsp_ready;
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Acceptance overrides the RESP->IDLE exit, giving back-to-back fetches.
      accept = bus.req_valid & bus.req_ready;
      if (accept) begin
         state_d = (LATENCY == 1) ? RESP : WAIT;
         cnt_d   = CNT_INIT;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) err_q <= req_err;
      end
   end

   imem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (load_en & load_ok),
      .waddr (wr_idx),
      .wdata (load_data),
      .re    (accept & ~req_err),
      .raddr (rd_idx),
      .rdata (rd_word)
   );

   assign bus.rsp_err  = err_q;
   assign bus.rsp_data = err_q ? 32'h0 : rd_word;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: latency, back-to-back, backpressure, errors,
// read/write collision and reset during an in-flight fetch.
module tb_imem_responder;

   logic        clk;
   logic        reset;
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   int          tests;
   int          fails;

   imem_responder_if bus();

   imem_responder #(
      .BASE        (32'h8000_0000),
      .DEPTH_WORDS (1024),
      .LATENCY     (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      next_cycle();
      load_en   = 1'b0;
   endtask

   // Single fetch with rsp_ready held high; called just after a rising edge.
   task automatic fetch_one(input string tag, input logic [31:0] a,
                            input logic [31:0] exp_data, input logic exp_err);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check({tag, ".ready_idle"}, 32'(bus.req_ready), 32'd1);
      next_cycle();
      bus.req_valid = 1'b0;
      load_en       = 1'b0;
      @(negedge clk);
      check({tag, ".wait_valid"}, 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      check({tag, ".valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, ".data"},  bus.rsp_data, exp_data);
      check({tag, ".err"},   32'(bus.rsp_err), 32'(exp_err));
      next_cycle();
      @(negedge clk);
      check({tag, ".idle_valid"}, 32'(bus.rsp_valid), 32'd0);
      next_cycle();
   endtask

   initial begin
      tests         = 0;
      fails         = 0;
      reset         = 1'b0;
      load_en       = 1'b0;
      load_addr     = '0;
      load_data     = '0;
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h8000_0000;
      bus.rsp_ready = 1'b1;

      #2;
      check("rst.req_ready", 32'(bus.req_ready), 32'd0);
      check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst.rsp_data",  bus.rsp_data, 32'h0);
      check("rst.rsp_err",   32'(bus.rsp_err), 32'd0);
      bus.req_valid = 1'b0;
      next_cycle();
      next_cycle();
      reset = 1'b1;
      next_cycle();

      preload(32'h8000_0000, 32'h0010_0093);
      preload(32'h8000_0004, 32'h0020_0113);
      preload(32'h8000_0FFC, 32'hCAFE_F00D);
      preload(32'h8000_1000, 32'h1111_1111);   // outside window, must be dropped

      // Basic fetch: rsp_valid two edges after the request is presented.
      fetch_one("t1", 32'h8000_0000, 32'h0010_0093, 1'b0);

      // Back-to-back with req_valid held.
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h8000_0000;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("t2.ready0", 32'(bus.req_ready), 32'd1);
      next_cycle();
      bus.req_addr = 32'h8000_0004;
      @(negedge clk);
      check("t2.wait_ready", 32'(bus.req_ready), 32'd0);
      check("t2.wait_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      check("t2.valid0", 32'(bus.rsp_valid), 32'd1);
      check("t2.data0",  bus.rsp_data, 32'h0010_0093);
      check("t2.resp_ready0", 32'(bus.req_ready), 32'd1);
      next_cycle();
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("t2.wait_ready1", 32'(bus.req_ready), 32'd0);
      check("t2.wait_valid1", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      check("t2.valid1", 32'(bus.rsp_valid), 32'd1);
      check("t2.data1",  bus.rsp_data, 32'h0020_0113);
      check("t2.resp_ready1", 32'(bus.req_ready), 32'd1);
      next_cycle();
      @(negedge clk);
      check("t2.idle", 32'(bus.rsp_valid), 32'd0);
      next_cycle();

      // Backpressure; req_addr changes after acceptance must not matter.
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h8000_0004;
      bus.rsp_ready = 1'b0;
      next_cycle();
      bus.req_valid = 1'b0;
      bus.req_addr  = 32'h8000_0002;
      next_cycle();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t3.hold_valid", 32'(bus.rsp_valid), 32'd1);
         check("t3.hold_data",  bus.rsp_data, 32'h0020_0113);
         check("t3.hold_err",   32'(bus.rsp_err), 32'd0);
         check("t3.hold_ready", 32'(bus.req_ready), 32'd0);
         next_cycle();
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("t3.release_ready", 32'(bus.req_ready), 32'd1);
      next_cycle();
      @(negedge clk);
      check("t3.single", 32'(bus.rsp_valid), 32'd0);
      next_cycle();

      // Error fetches and window boundaries.
      fetch_one("t4.misalign", 32'h8000_0002, 32'h0, 1'b1);
      fetch_one("t4.below",    32'h7FFF_FFFC, 32'h0, 1'b1);
      fetch_one("t4.above",    32'h8000_1000, 32'h0, 1'b1);
      fetch_one("t4.last",     32'h8000_0FFC, 32'hCAFE_F00D, 1'b0);
      fetch_one("t4.nodrop",   32'h8000_0000, 32'h0010_0093, 1'b0);

      // Preload colliding with the acceptance edge: old word first, new word after.
      load_en   = 1'b1;
      load_addr = 32'h8000_0000;
      load_data = 32'hDEAD_BEEF;
      fetch_one("t5.old", 32'h8000_0000, 32'h0010_0093, 1'b0);
      fetch_one("t5.new", 32'h8000_0000, 32'hDEAD_BEEF, 1'b0);

      // Reset during WAIT discards the in-flight response.
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h8000_0004;
      bus.rsp_ready = 1'b1;
      next_cycle();
      bus.req_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("t6.rst_valid", 32'(bus.rsp_valid), 32'd0);
      check("t6.rst_ready", 32'(bus.req_ready), 32'd0);
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      check("t6.after0", 32'(bus.rsp_valid), 32'd0);
      next_cycle();
      @(negedge clk);
      check("t6.after1", 32'(bus.rsp_valid), 32'd0);
      next_cycle();
      fetch_one("t6.mem1", 32'h8000_0004, 32'h0020_0113, 1'b0);
      fetch_one("t6.mem0", 32'h8000_0000, 32'hDEAD_BEEF, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
